// File: rtl/cpc_bus_pkg.sv
// Shared cycle-class and FSM encodings for the Z80 bus cycle decoder.
package cpc_bus_pkg;

  typedef enum logic [2:0] {
    CYC_NONE    = 3'd0,
    CYC_OPFETCH = 3'd1,
    CYC_MEMRD   = 3'd2,
    CYC_MEMWR   = 3'd3,
    CYC_REFRESH = 3'd4,
    CYC_IORD    = 3'd5,
    CYC_IOWR    = 3'd6,
    CYC_INTACK  = 3'd7
  } cyc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] BANK_SEL_TAG = 2'b11;

  // IO-class cycles are owned by /IORQ, everything else by /MREQ.
  function automatic logic is_io_cycle(input cyc_type_e t);
    return (t == CYC_IORD) || (t == CYC_IOWR) || (t == CYC_INTACK);
  endfunction

endpackage

// File: rtl/cpc_strobe_edge.sv
// Registers one active-low bus strobe and reports its fall/rise on the sampling edge.
module cpc_strobe_edge (
  input  logic clk,
  input  logic reset_b,
  input  logic strobe_b_i,
  output logic fall_o,
  output logic rise_o
);

  logic strobe_b_q;
  logic seen_high_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      strobe_b_q  <= 1'b1;
      seen_high_q <= 1'b0;
    end else begin
      strobe_b_q <= strobe_b_i;
      if (strobe_b_i) seen_high_q <= 1'b1;
    end
  end

  // A strobe already low when reset releases must go high before a fall counts.
  always_comb begin
    fall_o = seen_high_q & strobe_b_q & ~strobe_b_i;
    rise_o = ~strobe_b_q & strobe_b_i;
  end

endmodule

// File: rtl/cpc_bus_cycle_decoder.sv
// Classifies Z80 bus cycles, counts READY waits and owns the 0x7FXX bank-select register.
module cpc_bus_cycle_decoder
  import cpc_bus_pkg::*;
#(
  parameter int unsigned WAIT_CNT_W = 4,
  parameter int unsigned BANK_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  mreq_b,
  input  logic                  iorq_b,
  input  logic                  rd_b,
  input  logic                  wr_b,
  input  logic                  m1_b,
  input  logic                  rfsh_b,
  input  logic                  ready,
  input  logic                  adr15,
  input  logic                  adr14,
  input  logic [7:0]            data,
  output logic                  cyc_valid,
  output logic [2:0]            cyc_type,
  output logic [1:0]            adr_hi_q,
  output logic                  cyc_end,
  output logic [WAIT_CNT_W-1:0] wait_cnt,
  output logic [BANK_W-1:0]     ramblock_q
  ,output logic                 bank_wr
);

  state_e                state_q, state_d;
  cyc_type_e             cyc_type_q, class_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  bank_wr_q;
  logic                  mreq_fall, mreq_rise, iorq_fall, iorq_rise;
  logic                  start_ok, start, owner_rise, bank_load;

  cpc_strobe_edge u_mreq_edge (
    .clk        (clk),
    .reset_b    (reset_b),
    .strobe_b_i (mreq_b),
    .fall_o     (mreq_fall),
    .rise_o     (mreq_rise)
  );

  cpc_strobe_edge u_iorq_edge (
    .clk        (clk),
    .reset_b    (reset_b),
    .strobe_b_i (iorq_b),
    .fall_o     (iorq_fall),
    .rise_o     (iorq_rise)
  );

  // MREQ has priority when both strobes fall on the same edge.
  always_comb begin
    class_d = CYC_NONE;
    if (mreq_fall) begin
      if (!rfsh_b)    class_d = CYC_REFRESH;
      else if (!m1_b) class_d = CYC_OPFETCH;
      else if (!rd_b) class_d = CYC_MEMRD;
      else            class_d = CYC_MEMWR;
    end else if (iorq_fall) begin
      if (!m1_b)      class_d = CYC_INTACK;
      else if (!rd_b) class_d = CYC_IORD;
      else            class_d = CYC_IOWR;
    end
  end

  always_comb begin
    start_ok   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    start      = start_ok & (mreq_fall | iorq_fall);
    owner_rise = is_io_cycle(cyc_type_q) ? iorq_rise : mreq_rise;
    bank_load  = start & (class_d == CYC_IOWR) & ~wr_b & ~adr15 &
                 (data[7:6] == BANK_SEL_TAG);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACTIVE;
      ST_ACTIVE: if (owner_rise) state_d = ST_DONE;
                 else if (!ready) state_d = ST_WAIT;
      ST_WAIT:   if (owner_rise) state_d = ST_DONE;
                 else if (ready) state_d = ST_ACTIVE;
      ST_DONE:   state_d = start ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_valid = (state_q == ST_ACTIVE) || (state_q == ST_WAIT);
    cyc_end   = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cyc_type_q <= CYC_NONE;
      adr_hi_q   <= '0;
      wait_cnt_q <= '0;
      bank_wr_q  <= 1'b0;
      ramblock_q <= '0;
    end else begin
      bank_wr_q <= bank_load;
      if (bank_load) ramblock_q <= data[BANK_W-1:0];
      if (start) begin
        cyc_type_q <= class_d;
        adr_hi_q   <= {adr15, adr14};
        wait_cnt_q <= '0;
      end else begin
        if (state_d == ST_IDLE) begin
          cyc_type_q <= CYC_NONE;
          adr_hi_q   <= '0;
        end
        if (state_q == ST_WAIT && wait_cnt_q != '1)
          wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
      end
    end
  end

  always_comb begin
    cyc_type = cyc_type_q;
    wait_cnt = wait_cnt_q;
    bank_wr  = bank_wr_q;
  end

endmodule
